fu_issue_sched: RTL and testbench
=================================

FU_ISSUE_SCHED -- requirements
Module: fu_issue_sched

Interface
REQ-001 The block SHALL have parameter NUM_RS, default 16: number of reservation-station rows; fixed at 16 for this release.
REQ-002 The block SHALL have parameter NUM_FU, default 3: number of functional units; fixed at 3.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1: rising-edge clock.
REQ-005 Port rst_n  input  1: asynchronous active-low reset.
REQ-006 Port flush  input  1: synchronous pipeline flush.
REQ-007 Port rs_req  input  16: bit k=1 means RS row k is in use and both sources are ready.
REQ-008 Port rs_fu_sel  input  32: bits [2k+1:2k] give the FU index requested by row k; value 3 is invalid.
REQ-009 Port fu_ready  input  3: bit f=1 means FU f accepts an instruction this cycle.
REQ-010 Port issue_valid  output  3: bit f=1 means FU f is issued a row this cycle.
REQ-011 Port issue_idx  output  12: bits [4f+3:4f] give the RS row issued to FU f; valid only with issue_valid[f].
REQ-012 Port rs_clear  output  16: one-hot-per-grant mask of rows the RS frees at the next edge.
REQ-013 Port issue_count  output  32: total number of grants made (see Configuration).

Function
REQ-014 The eligible set in cycle N SHALL be rows k with rs_req[k]=1, rs_fu_sel(k)!=3, and k not in the held mask.
REQ-015 For each FU f with fu_ready[f]=1 in cycle N, the block SHALL select one eligible row with rs_fu_sel=f, searching round-robin upward from rr_ptr[f] and wrapping 15->0.
REQ-016 Each selection SHALL be registered: issue_valid, issue_idx and rs_clear SHALL reflect the cycle-N decision during cycle N+1, giving one-cycle latency.
REQ-017 When FU f has fu_ready[f]=0 or no eligible row, issue_valid[f] SHALL be 0 in cycle N+1, and issue_idx for that FU SHALL hold its previous value.
REQ-018 On a grant of row k to FU f, rr_ptr[f] SHALL become (k+1) mod 16; otherwise rr_ptr[f] SHALL hold.
REQ-019 Rows granted in cycle N SHALL be in the held mask during cycle N+1 only, so that no row is granted twice before the RS clears it.
REQ-020 A row SHALL never be granted to more than one FU in the same cycle.
REQ-021 rs_clear SHALL equal the OR of one-hot(issue_idx[f]) over all f with issue_valid[f]=1.
REQ-022 Rows with rs_fu_sel=3 SHALL never be granted and SHALL NOT move any pointer.
REQ-023 Flush in cycle N SHALL force issue_valid=0 and rs_clear=0 in cycle N+1, SHALL clear the held mask, and SHALL reset all rr_ptr to 0.
REQ-024 Flush SHALL take priority over any simultaneous request.
REQ-025 The three FUs SHALL arbitrate independently; fu_ready changes SHALL take effect in the next decision with no extra delay.

Reset
REQ-026 While rst_n=0, the block SHALL hold issue_valid=0, issue_idx=0, rs_clear=0, issue_count=0, held mask=0, and all rr_ptr=0.
REQ-027 Reset assertion mid-operation SHALL clear all state immediately, independent of clk.
REQ-028 The first decision SHALL be taken at the first rising edge after rst_n deasserts.

Configuration
REQ-029 With macro FU_ISSUE_CNT_EN defined, issue_count SHALL add the number of set issue_valid bits (0-3) each cycle, wrapping modulo 2^32.
REQ-030 Without FU_ISSUE_CNT_EN, issue_count SHALL be tied to 0 and no counter logic SHALL be present.
REQ-031 Grant behaviour SHALL be identical with and without FU_ISSUE_CNT_EN.

Verification
REQ-032 Single request: rs_req=0x0010, row 4 sel=1, fu_ready=3'b111 -> next cycle issue_valid=3'b010, idx[FU1]=4, rs_clear=0x0010; row 4 is not regranted in the following cycle.
REQ-033 Round-robin wrap: rows 2 and 14 sel=0, held permanently, rr_ptr[0]=0 -> grants 2, 14, 2, 14 on alternate eligible cycles; after 14 the pointer wraps to 0.
REQ-034 Parallel issue: rows 0, 1, 2 with sel 0, 1, 2 and all FUs ready -> one cycle later issue_valid=3'b111 and rs_clear=0x0007; with FU_ISSUE_CNT_EN, issue_count increments by 3.
REQ-035 Back-pressure and invalid select: row 5 sel=2 with fu_ready[2]=0 for 3 cycles -> no grant; grant follows one cycle after fu_ready[2] rises. Row 6 sel=3 -> never granted.
REQ-036 Flush and reset: flush asserted together with rows requesting -> next cycle issue_valid=0 and pointers=0. Asserting rst_n=0 mid-grant clears outputs without waiting for a clock edge.

Source files
------------

// File: rtl/fu_issue_sched.sv
// fu_issue_sched -- per-FU round-robin issue scheduler for a 16-row reservation station.
//
// Each functional unit picks, from the rows that request it and are eligible,
// the first one at or above its own round-robin pointer (wrapping). Decisions
// are registered, so grants appear one cycle after the inputs that caused them.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous flush: kills next-cycle grants, zeroes pointers and held mask
//   rs_req       per-row "in use and sources ready"
//   rs_fu_sel    2 bits per row: requested FU (3 = invalid, never granted)
//   fu_ready     per-FU accept
//   issue_valid  per-FU grant this cycle
//   issue_idx    4 bits per FU: granted row (holds when no grant)
//   rs_clear     rows freed at the next edge (OR of granted one-hots)
//   issue_count  running grant total
//
// Build option: define FU_ISSUE_CNT_EN to enable the issue_count counter;
// otherwise issue_count is tied to 0.

module fu_issue_sched #(
   parameter int NUM_RS = 16,
   parameter int NUM_FU = 3
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic [NUM_RS-1:0]                 rs_req,
   input  logic [2*NUM_RS-1:0]               rs_fu_sel,
   input  logic [NUM_FU-1:0]                 fu_ready,
   output logic [NUM_FU-1:0]                 issue_valid,
   output logic [$clog2(NUM_RS)*NUM_FU-1:0]  issue_idx,
   output logic [NUM_RS-1:0]                 rs_clear,
   output logic [31:0]                       issue_count
);

   localparam int IDX_W = $clog2(NUM_RS);

   logic [NUM_RS-1:0][1:0]         sel;
   logic [NUM_RS-1:0]              elig;
   logic [NUM_RS-1:0]              held_q, held_d;
   logic [NUM_FU-1:0]              gnt_v;
   logic [NUM_FU-1:0][NUM_RS-1:0]  gnt_oh;
   logic [NUM_FU:0][NUM_RS-1:0]    or_chain;

   assign sel = rs_fu_sel;

   for (genvar k = 0; k < NUM_RS; k++) begin : g_row
      assign elig[k] = rs_req[k] & (sel[k] != 2'd3) & ~held_q[k];
   end

   for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
      logic             hit;
      logic [IDX_W-1:0] row, cand;
      logic             vld_q;
      logic [IDX_W-1:0] idx_q, ptr_q;

      // Scan downward in offset so the smallest offset from ptr_q wins.
      // Index arithmetic wraps naturally because NUM_RS is a power of two.
      always_comb begin
         hit  = 1'b0;
         row  = '0;
         cand = '0;
         for (int i = NUM_RS-1; i >= 0; i--) begin
            cand = ptr_q + IDX_W'(i);
            if (fu_ready[f] && elig[cand] && sel[cand] == 2'(f)) begin
               hit = 1'b1;
               row = cand;
            end
         end
      end

      assign gnt_v[f]  = hit & ~flush;
      assign gnt_oh[f] = gnt_v[f] ? (NUM_RS'(1) << row) : '0;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            idx_q <= '0;
            ptr_q <= '0;
         end else if (flush) begin
            vld_q <= 1'b0;
            ptr_q <= '0;
         end else begin
            vld_q <= hit;
            if (hit) begin
               idx_q <= row;
               ptr_q <= row + 1'b1;
            end
         end
      end

      assign issue_valid[f]              = vld_q;
      assign issue_idx[IDX_W*f +: IDX_W] = idx_q;
      assign or_chain[f+1]               = or_chain[f] | gnt_oh[f];
   end

   assign or_chain[0] = '0;
   assign held_d      = or_chain[NUM_FU];

   // Rows granted last cycle are exactly the ones the RS is freeing now, so
   // the held mask doubles as rs_clear. Flush leaves held_d at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) held_q <= '0;
      else        held_q <= held_d;
   end

   assign rs_clear = held_q;

`ifdef FU_ISSUE_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   // Counts grants at the decision edge so the total already includes the
   // issue_valid bits visible in the same cycle.
   assign cnt_d = cnt_q + 32'($countones(gnt_v));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign issue_count = cnt_q;
`else
   assign issue_count = '0;
`endif

endmodule

// File: tb/tb_fu_issue_sched.sv
module tb_fu_issue_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [15:0] rs_req;
   logic [31:0] rs_fu_sel;
   logic [2:0]  fu_ready;
   logic [2:0]  issue_valid;
   logic [11:0] issue_idx;
   logic [15:0] rs_clear;
   logic [31:0] issue_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int          m_ptr [3];
   logic [3:0]  m_idx [3];
   logic [15:0] m_held;
   logic [2:0]  exp_valid;
   logic [15:0] exp_clear;
   logic [31:0] exp_cnt;

   fu_issue_sched dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .rs_req(rs_req),
      .rs_fu_sel(rs_fu_sel), .fu_ready(fu_ready), .issue_valid(issue_valid),
      .issue_idx(issue_idx), .rs_clear(rs_clear), .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] exp_idx();
      return {m_idx[2], m_idx[1], m_idx[0]};
   endfunction

   function automatic logic [31:0] cnt_exp();
`ifdef FU_ISSUE_CNT_EN
      return exp_cnt;
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      for (int f = 0; f < 3; f++) begin m_ptr[f] = 0; m_idx[f] = '0; end
      m_held = '0; exp_valid = '0; exp_clear = '0; exp_cnt = '0;
   endtask

   // Evaluate the scheduling rules on the current inputs, then advance one
   // clock and sample 1 time unit after the edge.
   task automatic tick();
      logic [2:0]  v;
      logic [15:0] clr;
      v = '0; clr = '0;
      if (flush) begin
         for (int f = 0; f < 3; f++) m_ptr[f] = 0;
      end else begin
         for (int f = 0; f < 3; f++) begin
            if (((fu_ready >> f) & 3'd1) != 0) begin
               for (int i = 0; i < 16; i++) begin
                  int r;
                  r = (m_ptr[f] + i) % 16;
                  if (((v >> f) & 3'd1) == 0 && ((rs_req >> r) & 16'd1) != 0 &&
                      ((m_held >> r) & 16'd1) == 0 && int'(2'(rs_fu_sel >> (2*r))) == f) begin
                     v       |= 3'(1 << f);
                     clr     |= 16'(1 << r);
                     m_idx[f] = 4'(r);
                     m_ptr[f] = (r + 1) % 16;
                  end
               end
            end
         end
      end
      @(posedge clk); #1;
      exp_valid = v; exp_clear = clr; m_held = clr;
      exp_cnt  += 32'($countones(v));
   endtask

   task automatic idle_inputs();
      flush = 0; rs_req = '0; rs_fu_sel = '0; fu_ready = '0;
   endtask

   task automatic test_reset();
      rst_n = 0; idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (issue_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b want 000", issue_valid); end
      n_tests++;
      if (issue_idx !== 12'h000) begin n_fail++; $display("FAIL reset_idx: got %h want 000", issue_idx); end
      n_tests++;
      if (rs_clear !== 16'h0000) begin n_fail++; $display("FAIL reset_clear: got %h want 0000", rs_clear); end
      n_tests++;
      if (issue_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", issue_count); end
      @(negedge clk) rst_n = 1;
      model_reset();
   endtask

   task automatic test_single();
      idle_inputs();
      rs_req = 16'h0010; rs_fu_sel[9:8] = 2'd1; fu_ready = 3'b111;
      tick();
      n_tests++;
      if (issue_valid !== 3'b010) begin n_fail++; $display("FAIL single_valid: got %b want 010", issue_valid); end
      n_tests++;
      if (issue_idx[7:4] !== 4'd4) begin n_fail++; $display("FAIL single_idx: got %0d want 4", issue_idx[7:4]); end
      n_tests++;
      if (rs_clear !== 16'h0010) begin n_fail++; $display("FAIL single_clear: got %h want 0010", rs_clear); end
      tick();
      n_tests++;
      if (issue_valid !== 3'b000) begin n_fail++; $display("FAIL single_no_regrant: got %b want 000", issue_valid); end
      idle_inputs(); tick();
   endtask

   task automatic test_rr_wrap();
      logic [3:0] want [4];
      want[0] = 4'd2; want[1] = 4'd14; want[2] = 4'd2; want[3] = 4'd14;
      idle_inputs(); flush = 1; tick(); flush = 0;
      rs_req = 16'h4004; fu_ready = 3'b001;   // rows 2 and 14, sel 0
      for (int c = 0; c < 4; c++) begin
         tick();
         n_tests++;
         if (issue_valid !== 3'b001 || issue_idx[3:0] !== want[c]) begin
            n_fail++;
            $display("FAIL rr_wrap[%0d]: got v=%b idx=%0d want v=001 idx=%0d", c, issue_valid, issue_idx[3:0], want[c]);
         end
      end
      idle_inputs(); tick();
   endtask

   task automatic test_parallel();
      logic [31:0] c0;
      idle_inputs(); flush = 1; tick(); flush = 0;
      c0 = issue_count;
      rs_req = 16'h0007; rs_fu_sel[1:0] = 2'd0; rs_fu_sel[3:2] = 2'd1; rs_fu_sel[5:4] = 2'd2;
      fu_ready = 3'b111;
      tick();
      n_tests++;
      if (issue_valid !== 3'b111) begin n_fail++; $display("FAIL parallel_valid: got %b want 111", issue_valid); end
      n_tests++;
      if (rs_clear !== 16'h0007) begin n_fail++; $display("FAIL parallel_clear: got %h want 0007", rs_clear); end
      n_tests++;
      if (issue_idx !== 12'h210) begin n_fail++; $display("FAIL parallel_idx: got %h want 210", issue_idx); end
      n_tests++;
`ifdef FU_ISSUE_CNT_EN
      if (issue_count !== c0 + 32'd3) begin n_fail++; $display("FAIL parallel_count: got %0d want %0d", issue_count, c0 + 32'd3); end
`else
      if (issue_count !== 32'd0) begin n_fail++; $display("FAIL parallel_count: got %0d want 0 (c0=%0d)", issue_count, c0); end
`endif
      idle_inputs(); tick();
   endtask

   task automatic test_backpressure();
      idle_inputs();
      rs_req = 16'h0060; rs_fu_sel[11:10] = 2'd2; rs_fu_sel[13:12] = 2'd3;
      fu_ready = 3'b011;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_tests++;
         if (issue_valid !== 3'b000) begin n_fail++; $display("FAIL bp_stall[%0d]: got %b want 000", c, issue_valid); end
      end
      fu_ready = 3'b111;
      tick();
      n_tests++;
      if (issue_valid !== 3'b100 || issue_idx[11:8] !== 4'd5 || rs_clear !== 16'h0020) begin
         n_fail++;
         $display("FAIL bp_release: got v=%b idx=%0d clr=%h want v=100 idx=5 clr=0020", issue_valid, issue_idx[11:8], rs_clear);
      end
      rs_req = 16'h0040;   // only the invalid-select row remains
      repeat (3) begin
         tick();
         n_tests++;
         if (issue_valid !== 3'b000 || rs_clear !== 16'h0000) begin
            n_fail++; $display("FAIL sel3_grant: got v=%b clr=%h want v=000 clr=0000", issue_valid, rs_clear);
         end
      end
      idle_inputs(); tick();
   endtask

   task automatic test_flush();
      idle_inputs();
      rs_req = 16'h0200; fu_ready = 3'b001;   // row 9 sel 0 -> pointer 10
      tick();
      rs_req = 16'h1008; flush = 1;           // rows 3 and 12, sel 0
      tick();
      n_tests++;
      if (issue_valid !== 3'b000 || rs_clear !== 16'h0000) begin
         n_fail++; $display("FAIL flush_kill: got v=%b clr=%h want v=000 clr=0000", issue_valid, rs_clear);
      end
      flush = 0;
      tick();
      n_tests++;
      if (issue_valid !== 3'b001 || issue_idx[3:0] !== 4'd3) begin
         n_fail++; $display("FAIL flush_ptr: got v=%b idx=%0d want v=001 idx=3", issue_valid, issue_idx[3:0]);
      end
      idle_inputs(); tick();
   endtask

   task automatic test_async_reset();
      idle_inputs();
      rs_req = 16'h0007; rs_fu_sel[3:2] = 2'd1; rs_fu_sel[5:4] = 2'd2; fu_ready = 3'b111;
      tick();
      #2 rst_n = 0;
      #1;
      n_tests++;
      if (issue_valid !== 3'b000 || rs_clear !== 16'h0000 || issue_idx !== 12'h000 || issue_count !== 32'd0) begin
         n_fail++;
         $display("FAIL async_reset: got v=%b clr=%h idx=%h cnt=%0d want all 0", issue_valid, rs_clear, issue_idx, issue_count);
      end
      idle_inputs();
      @(negedge clk) rst_n = 1;
      model_reset();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rs_req    = 16'($urandom_range(0, 65535));
         rs_fu_sel = $urandom();
         fu_ready  = 3'($urandom_range(0, 7));
         flush     = ($urandom_range(0, 15) == 0);
         tick();
         n_tests++;
         if (issue_valid !== exp_valid || issue_idx !== exp_idx() || rs_clear !== exp_clear || issue_count !== cnt_exp()) begin
            n_fail++;
            $display("FAIL random[%0d]: got v=%b idx=%h clr=%h cnt=%0d want v=%b idx=%h clr=%h cnt=%0d",
                     c, issue_valid, issue_idx, rs_clear, issue_count, exp_valid, exp_idx(), exp_clear, cnt_exp());
         end
      end
      idle_inputs(); tick();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_rr_wrap();
      test_parallel();
      test_backpressure();
      test_flush();
      test_random();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
